// File: rtl/adder_ctrl_pkg.sv
// Shared types for the multi-channel adder controller.
// State encoding and the default opcode value.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int unsigned OP_DEFAULT = 0;

endpackage

// File: rtl/adder_ctrl_arb_rr_arbiter.sv
// Round-robin arbiter for the adder controller.
// Owns the priority pointer; search starts after it.
module rr_arbiter #(
  parameter int N_CH = 4,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            ACLK,
  input  logic            ARSTn,
  input  logic [N_CH-1:0] req,
  input  logic            upd,
  input  logic [CH_W-1:0] upd_idx,
  output logic            gnt_vld,
  output logic [CH_W-1:0] gnt
);

  logic [CH_W-1:0] ptr;

  // Pointer resets to the last channel so channel 0 wins first
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      ptr <= CH_W'(N_CH - 1);
    end else if (upd) begin
      ptr <= upd_idx;
    end
  end

  // First requester found walking up from ptr+1 with wrap
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!gnt_vld && req[(int'(ptr) + 1 + i) % N_CH]) begin
        gnt_vld = 1'b1;
        gnt     = CH_W'((int'(ptr) + 1 + i) % N_CH);
      end
    end
  end

endmodule

// File: rtl/adder_ctrl_arb.sv
// Multi-channel execute/write/done sequencer for the adder.
// Define ADDER_CTRL_B2B_EN to chain ops from DONE without IDLE.
module adder_ctrl_arb
  import adder_ctrl_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int OP_W     = 2,
  parameter int EXEC_LAT = 1,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int CNT_W = $clog2(EXEC_LAT + 1)
) (
  input  logic                 ACLK,
  input  logic                 ARSTn,
  input  logic [N_CH-1:0]      i_start,
  input  logic [N_CH*OP_W-1:0] i_op,
  output logic [N_CH-1:0]      o_is_busy,
  output logic [OP_W-1:0]      o_op,
  output logic [CH_W-1:0]      o_ch,
  output logic                 o_en_ctrl_write,
  output logic [N_CH-1:0]      o_rst_start,
  output logic [N_CH-1:0]      o_result_is_done,
  output logic                 o_idle
);

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CH_W-1:0] ch_n;
  logic [OP_W-1:0] op_n;
  logic            wr_n;
  logic [N_CH-1:0] rs_n;
  logic [N_CH-1:0] done_n;
  logic [N_CH-1:0] busy_n;
  logic            take;
  logic [N_CH-1:0] ch_oh;
  logic [N_CH-1:0] req;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt;

  assign ch_oh = N_CH'(1) << o_ch;
  assign req   = i_start
               & ~((state == S_DONE) ? ch_oh : '0);

  rr_arbiter #(.N_CH(N_CH)) u_arb (
    .ACLK    (ACLK),
    .ARSTn   (ARSTn),
    .req     (req),
    .upd     (take),
    .upd_idx (ch_n),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  // Next state, counter and output values
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ch_n    = o_ch;
    op_n    = o_op;
    wr_n    = 1'b0;
    rs_n    = '0;
    done_n  = '0;
    take    = 1'b0;
    busy_n  = i_start
            | ((state != S_IDLE) ? ch_oh : '0);
    unique case (state)
      S_IDLE: begin
        if (gnt_vld) begin
          take    = 1'b1;
          ch_n    = gnt;
          op_n    = i_op[int'(gnt)*OP_W +: OP_W];
          cnt_n   = CNT_W'(EXEC_LAT - 1);
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          wr_n    = 1'b1;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        rs_n    = ch_oh;
        state_n = S_DONE;
      end
      S_DONE: begin
        done_n  = ch_oh;
        state_n = S_IDLE;
`ifdef ADDER_CTRL_B2B_EN
        if (gnt_vld) begin
          take    = 1'b1;
          ch_n    = gnt;
          op_n    = i_op[int'(gnt)*OP_W +: OP_W];
          cnt_n   = CNT_W'(EXEC_LAT - 1);
          state_n = S_EXEC;
        end
`else
        take = 1'b0;
`endif
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge ACLK) begin
    if (!ARSTn) begin
      state            <= S_IDLE;
      cnt              <= '0;
      o_ch             <= '0;
      o_op             <= OP_W'(OP_DEFAULT);
      o_en_ctrl_write  <= 1'b0;
      o_rst_start      <= '0;
      o_result_is_done <= '0;
      o_is_busy        <= '0;
      o_idle           <= 1'b1;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      o_ch             <= ch_n;
      o_op             <= op_n;
      o_en_ctrl_write  <= wr_n;
      o_rst_start      <= rs_n;
      o_result_is_done <= done_n;
      o_is_busy        <= busy_n;
      o_idle           <= (state_n == S_IDLE);
    end
  end

endmodule

// File: tb/tb_adder_ctrl_arb.sv
// Directed bench for adder_ctrl_arb.
// Two instances: execute latency 1 and 5.
module tb_adder_ctrl_arb;

  logic       ACLK;
  logic       ARSTn;
  logic [3:0] i_start;
  logic [7:0] i_op;
  logic [3:0] o_is_busy;
  logic [1:0] o_op;
  logic [1:0] o_ch;
  logic       o_wr;
  logic [3:0] o_rs;
  logic [3:0] o_done;
  logic       o_idle;

  logic [3:0] s5;
  logic [7:0] op5;
  logic [3:0] busy5;
  logic [1:0] opo5;
  logic [1:0] ch5;
  logic       wr5;
  logic [3:0] rs5;
  logic [3:0] done5;
  logic       idle5;

  int n_tests = 0;
  int n_fail  = 0;

  adder_ctrl_arb #(.N_CH(4), .OP_W(2), .EXEC_LAT(1)) dut (
    .ACLK             (ACLK),
    .ARSTn            (ARSTn),
    .i_start          (i_start),
    .i_op             (i_op),
    .o_is_busy        (o_is_busy),
    .o_op             (o_op),
    .o_ch             (o_ch),
    .o_en_ctrl_write  (o_wr),
    .o_rst_start      (o_rs),
    .o_result_is_done (o_done),
    .o_idle           (o_idle)
  );

  adder_ctrl_arb #(.N_CH(4), .OP_W(2), .EXEC_LAT(5)) dut5 (
    .ACLK             (ACLK),
    .ARSTn            (ARSTn),
    .i_start          (s5),
    .i_op             (op5),
    .o_is_busy        (busy5),
    .o_op             (opo5),
    .o_ch             (ch5),
    .o_en_ctrl_write  (wr5),
    .o_rst_start      (rs5),
    .o_result_is_done (done5),
    .o_idle           (idle5)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic do_reset;
    ARSTn = 1'b0;
    tick();
    tick();
    ARSTn = 1'b1;
  endtask

  int order[4];
  int n_ord;
  int n;
  int t_done;
  int t_gnt;
  bit idle_seen;

  initial begin
    ARSTn   = 1'b0;
    i_start = 4'b1111;
    i_op    = 8'h00;
    s5      = 4'b0000;
    op5     = 8'h00;

    // reset held with all starts pending
    tick(); tick(); tick();
    chk("rst_idle", o_idle, 1);
    chk("rst_busy", o_is_busy, 0);
    chk("rst_ch", o_ch, 0);
    chk("rst_op", o_op, 0);
    chk("rst_wr", o_wr, 0);
    chk("rst_rs", o_rs, 0);
    chk("rst_done", o_done, 0);
    ARSTn = 1'b1;
    tick();
    chk("first_ch", o_ch, 0);
    chk("first_idle", o_idle, 0);
    i_start = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("first_back_idle", o_idle, 1);

    // single op on channel 2, opcode 3
    i_op    = 8'b00_11_00_00;
    i_start = 4'b0100;
    tick();
    chk("s_ch", o_ch, 2);
    chk("s_op", o_op, 3);
    chk("s_wr_k", o_wr, 0);
    tick();
    chk("s_wr_k1", o_wr, 1);
    chk("s_rs_k1", o_rs, 0);
    tick();
    chk("s_wr_k2", o_wr, 0);
    chk("s_rs_k2", o_rs, 4'b0100);
    i_start = 4'b0000;
    tick();
    chk("s_done_k3", o_done, 4'b0100);
    chk("s_rs_k3", o_rs, 0);
    chk("s_busy_k3", o_is_busy, 4'b0100);
    tick();
    chk("s_done_k4", o_done, 0);
    chk("s_busy_k4", o_is_busy, 0);
    chk("s_idle_k4", o_idle, 1);

    // round robin from a fresh pointer
    do_reset();
    i_start = 4'b1111;
    n_ord = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (o_rs != 4'b0000) begin
        if (n_ord < 4) order[n_ord] = int'(o_ch);
        n_ord++;
        chk("rr_rs_onehot", o_rs,
            4'b0001 << o_ch);
        i_start = i_start & ~o_rs;
      end
      if (i_start == 4'b0000 && o_idle) break;
    end
    chk("rr_count", n_ord, 4);
    for (int i = 0; i < 4; i++)
      chk("rr_order", order[i], i);

    // execute latency 5 on second instance
    op5 = 8'b01_00_00_00;
    s5  = 4'b1000;
    tick();
    chk("l5_ch", ch5, 3);
    chk("l5_op", opo5, 1);
    s5 = 4'b0000;
    n = 0;
    while (!wr5 && n < 20) begin
      tick();
      n++;
    end
    chk("l5_lat", n, 5);
    tick(); tick(); tick();
    chk("l5_idle", idle5, 1);

    // drop own start and raise channel 3 mid-op
    do_reset();
    i_op    = 8'b00_00_10_00;
    i_start = 4'b0010;
    tick();
    chk("m_ch", o_ch, 1);
    chk("m_op", o_op, 2);
    i_start = 4'b1000;
    tick();
    chk("m_wr", o_wr, 1);
    chk("m_busy", o_is_busy, 4'b1010);
    tick();
    chk("m_rs", o_rs, 4'b0010);
    tick();
    chk("m_done", o_done, 4'b0010);
    n = 0;
    while (!(o_ch == 2'd3 && !o_idle) && n < 10) begin
      tick();
      n++;
    end
    chk("m_next_ch", o_ch, 3);
    chk("m_next_busy", o_is_busy[3], 1);
    i_start = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("m_idle", o_idle, 1);

    // reset in WRITE aborts without done
    i_start = 4'b0001;
    tick();
    i_start = 4'b0000;
    tick();
    chk("a_wr", o_wr, 1);
    ARSTn = 1'b0;
    tick();
    chk("a_wr0", o_wr, 0);
    chk("a_rs0", o_rs, 0);
    chk("a_done0", o_done, 0);
    chk("a_idle", o_idle, 1);
    ARSTn = 1'b1;
    tick();
    chk("a_done1", o_done, 0);
    chk("a_rs1", o_rs, 0);
    tick();
    chk("a_done2", o_done, 0);

    // two channels back to back
    do_reset();
    i_start = 4'b0011;
    tick();
    chk("b_ch0", o_ch, 0);
    t_done = -1;
    t_gnt  = -1;
    idle_seen = 1'b0;
    for (int c = 1; c < 15; c++) begin
      tick();
      if (o_rs != 4'b0000)
        i_start = i_start & ~o_rs;
      if (o_done == 4'b0001) t_done = c;
      if (o_ch == 2'd1 && !o_idle) begin
        t_gnt = c;
        break;
      end
      if (o_idle) idle_seen = 1'b1;
    end
    chk("b_done_seen", (t_done >= 0), 1);
    chk("b_gnt_seen", (t_gnt >= 0), 1);
`ifdef ADDER_CTRL_B2B_EN
    chk("b_gap", t_gnt - t_done, 0);
    chk("b_no_idle", idle_seen, 0);
`else
    chk("b_gap", t_gnt - t_done, 1);
    chk("b_idle", idle_seen, 1);
`endif
    i_start = 4'b0000;
    tick(); tick(); tick(); tick();
    chk("b_end_idle", o_idle, 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_ctrl_arb.md
Name: adder_ctrl_arb

Overview:
- Multi-channel execution controller for the AMBA-attached adder; successor of the single-channel start/execute/write/done sequencer.
- Serves N_CH register-bank channels, each with its own start bit and opcode, sharing one adder datapath.
- Round-robin arbitration between channels; configurable execute latency for multi-cycle datapaths.
- Sits between the AMBA register bank (start/op in; busy/start-clear/done out) and the adder datapath (op/channel/write-enable out).

Parameters:
N_CH, 4, number of channels (>=1)
OP_W, 2, opcode width per channel
EXEC_LAT, 1, execute cycles before result write strobe (>=1)
(localparams: CH_W = max(1,$clog2(N_CH)); CNT_W = $clog2(EXEC_LAT+1))

Ports:
ACLK  in  1  clock
ARSTn  in  1  reset; synchronous to ACLK, active-low
i_start  in  N_CH  per-channel start bit from register bank
i_op  in  N_CH*OP_W  per-channel opcode; channel c at [c*OP_W +: OP_W]
o_is_busy  out  N_CH  per-channel busy; AMBA must not write that channel's registers
o_op  out  OP_W  opcode of granted channel, held for the whole operation
o_ch  out  CH_W  granted channel index, held for the whole operation
o_en_ctrl_write  out  1  one-cycle result write strobe to the datapath
o_rst_start  out  N_CH  one-hot, one-cycle clear of the granted channel's start bit
o_result_is_done  out  N_CH  one-hot, one-cycle done pulse
o_idle  out  1  high when state is IDLE

Behaviour:
- All outputs are registered. Reset (ARSTn=0 at a clock edge): every output is 0 except o_idle=1; state=IDLE; RR pointer=N_CH-1, so channel 0 has first priority; counter=0.
- Reset mid-operation aborts immediately with no write strobe and no done pulse.
- States: IDLE, EXEC, WRITE, DONE (enum in package).
- IDLE:
  - If any i_start bit is set, grant the first set bit searching from pointer+1 with wrap-around.
  - Latch o_ch and o_op; pointer<=grant; counter<=EXEC_LAT-1; go to EXEC.
- EXEC:
  - If counter!=0, decrement and stay.
  - If counter==0, set o_en_ctrl_write<=1 and go to WRITE.
- WRITE: o_en_ctrl_write<=0; o_rst_start[o_ch]<=1; go to DONE.
- DONE: o_rst_start<=0; o_result_is_done[o_ch]<=1; go to IDLE. The done pulse drops on the next edge.
- Timing (grant edge = k):
  - o_en_ctrl_write is high in cycle k+EXEC_LAT..k+EXEC_LAT+1.
  - o_rst_start is high in the next cycle.
  - o_result_is_done is high in the cycle after that.
  - With EXEC_LAT=1 this matches the previous single-channel cadence.
- o_is_busy[c] is registered as (i_start[c] | (not IDLE & o_ch==c)). Pending channels report busy.
- Deassertion of i_start[o_ch] mid-operation is ignored; the operation completes.
- Start bits of other channels arriving mid-operation stay pending and are arbitrated in the next IDLE.
- Without the optional feature there is at least one IDLE cycle between operations.
- N_CH=1: arbitration degenerates; o_ch stays 0.

Optional Feature:
ADDER_CTRL_B2B_EN
- Defined: in DONE, if (i_start & ~onehot(o_ch)) is nonzero, grant the next channel by RR and go directly to EXEC, skipping IDLE. o_is_busy of the new channel stays high and o_idle stays 0. The done pulse for the old channel is still issued in that same cycle.
- Undefined: DONE always returns to IDLE.

Decomposition:
- Package adder_ctrl_pkg: state enum (logic [1:0]: IDLE, EXEC, WRITE, DONE) and a default-opcode constant.
- Sub-module rr_arbiter #(N_CH):
  - Inputs: req[N_CH], update strobe, grant index.
  - Outputs: grant_valid, grant index.
  - Owns the RR pointer and its reset value.
- FSM, counter and output registers live in adder_ctrl_arb.

Test Plan:
- Reset: hold ARSTn=0 for 3 cycles with i_start=4'b1111 -> all outputs 0, o_idle=1; release -> channel 0 granted first (o_ch=0).
- Single op, EXEC_LAT=1: i_start=4'b0100, op2=2'b11 -> o_ch=2, o_op=3; o_en_ctrl_write at k+1; o_rst_start=4'b0100 at k+2; o_result_is_done=4'b0100 at k+3; o_is_busy[2] low after the done pulse.
- Round robin: i_start=4'b1111 held, each channel's start cleared on its own o_rst_start -> grant order 0,1,2,3 with no channel repeated.
- Latency: EXEC_LAT=5 -> exactly 5 EXEC cycles between grant and o_en_ctrl_write.
- Mid-op events: drop i_start[o_ch] during EXEC -> op completes normally. Raise i_start[3] during EXEC -> o_is_busy[3]=1 next cycle and channel 3 is granted after DONE. Assert ARSTn=0 in WRITE -> no done pulse, all outputs 0.
- ADDER_CTRL_B2B_EN defined with i_start=4'b0011 -> channel 1 enters EXEC on the edge after the DONE cycle of channel 0; o_idle never rises between them.
